// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter that shares one FPU engine among NREQ
// requesters. One operation is in flight at a time; a watchdog aborts an
// operation the engine never finishes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for requests; req_ready pulses for the round-robin winner
// ISSUE | eng_start high for one cycle with the latched operands
// WAIT  | waiting for eng_done; watchdog counting toward TIMEOUT
// RESP  | rsp_valid held with result until rsp_ready
module fpu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_id,
    output logic [31:0]       rsp_data,
    output logic [3:0]        rsp_status,
    output logic              eng_start,
    output logic [31:0]       eng_a,
    output logic [31:0]       eng_b,
    output logic [1:0]        eng_op,
    input  logic              eng_done,
    input  logic [31:0]       eng_data,
    input  logic [3:0]        eng_status,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  last_grant;
    logic [2:0]  cur_id;
    logic [31:0] cur_a;
    logic [31:0] cur_b;
    logic [1:0]  cur_op;
    logic [6:0]  cnt;
    logic [31:0] rsp_data_q;
    logic [3:0]  rsp_status_q;

    logic        win_found;
    logic [2:0]  win_idx;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  sel_op;
    logic        in_flight;
    int          k;

    // Round-robin search starting just after the previous winner, wrapping at NREQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int i = 1; i <= NREQ; i++) begin
            k = int'(last_grant) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!win_found && req_valid[k]) begin
                win_found = 1'b1;
                win_idx   = k[2:0];
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win_idx == 3'(j)) begin
                sel_a  = req_a[j*32 +: 32];
                sel_b  = req_b[j*32 +: 32];
                sel_op = req_op[j*2 +: 2];
            end
        end
    end

    // One-hot accept strobe, only offered while idle.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (state_q == ST_IDLE && win_found && win_idx == 3'(j))
                req_ready[j] = 1'b1;
        end
    end

    // Main sequencer: accept, issue, wait with watchdog, respond.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant   <= 3'(NREQ - 1);
            cur_id       <= '0;
            cur_a        <= '0;
            cur_b        <= '0;
            cur_op       <= '0;
            cnt          <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        cur_id  <= win_idx;
                        cur_a   <= sel_a;
                        cur_b   <= sel_b;
                        cur_op  <= sel_op;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                    if (eng_done) begin
                        rsp_data_q   <= eng_data;
                        rsp_status_q <= eng_status;
                        state_q      <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 7'd1;
                    // A done arriving on the watchdog cycle still reports real data.
                    if (eng_done) begin
                        rsp_data_q   <= eng_data;
                        rsp_status_q <= eng_status;
                        state_q      <= ST_RESP;
                    end else if (cnt == 7'(TIMEOUT - 1)) begin
                        rsp_data_q   <= '0;
                        rsp_status_q <= 4'b0000;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        last_grant <= cur_id;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_flight  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign eng_start  = (state_q == ST_ISSUE);
    assign eng_a      = in_flight ? cur_a  : '0;
    assign eng_b      = in_flight ? cur_b  : '0;
    assign eng_op     = in_flight ? cur_op : '0;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = cur_id;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
